// File: rtl/simd_pl_core.sv
// Programmable-logic core of the SIMD 2x2 matrix processor: PC, decoder, control FSM,
// A/B/C matrix registers and two 32-bit MAC lanes, with BRAM port B for matrix data.
module simd_pl_core #(
  parameter int N     = 512,
  parameter int LANES = 2
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START_SIGNAL,
  output logic                 STOP_SIGNAL,
  output logic [$clog2(N)-1:0] PC_AXI,
  input  logic [31:0]          INSTR_AXI,
  output logic [31:0]          addrb,
  output logic [31:0]          dinb,
  input  logic [31:0]          doutb,
  output logic                 enb,
  output logic [3:0]           web
);

  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOADA = 3'b010,
    OP_LOADB = 3'b011,
    OP_MULT  = 3'b100,
    OP_STORE = 3'b101,
    OP_STOP  = 3'b110
  } opcode_t;

  state_t      state;
  logic [2:0]  op;
  logic [2:0]  fld;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [PW-1:0] pc_next;

  logic [31:0] mat_a [LANES][LANES];
  logic [31:0] mat_b [LANES][LANES];
  logic [31:0] mat_c [LANES][LANES];
  logic [31:0] c_tmp [LANES][LANES];
  logic [31:0] lane  [LANES];

  // Reserved instruction bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{INSTR_AXI[31:13], INSTR_AXI[9:3]};

  assign pc_next = (PC_AXI == PW'(N - 1)) ? '0 : PC_AXI + 1'b1;
  assign cnt_nxt = cnt + 2'd1;

  function automatic logic [31:0] word_addr(input logic [2:0] f, input logic [1:0] k);
    return (({29'd0, f} << 1) + {30'd0, k}) << 2;
  endfunction

  // Each MAC lane produces one column of the C row selected by cnt[0].
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane[i] = '0;
      for (int unsigned k = 0; k < LANES; k++)
        lane[i] = lane[i] + mat_a[cnt[0]][k] * mat_b[k][i];
    end
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state       <= IDLE;
      PC_AXI      <= '0;
      op          <= '0;
      fld         <= '0;
      cnt         <= '0;
      addrb       <= '0;
      dinb        <= '0;
      enb         <= 1'b0;
      web         <= '0;
      STOP_SIGNAL <= 1'b0;
      for (int unsigned r = 0; r < LANES; r++)
        for (int unsigned c = 0; c < LANES; c++) begin
          mat_a[r][c] <= '0;
          mat_b[r][c] <= '0;
          mat_c[r][c] <= '0;
          c_tmp[r][c] <= '0;
        end
    end else begin
      case (state)
        IDLE: if (START_SIGNAL) state <= FETCH;
        FETCH: begin
          op    <= INSTR_AXI[2:0];
          fld   <= INSTR_AXI[12:10];
          state <= DECODE;
        end
        DECODE: begin
          cnt <= '0;
          case (op)
            OP_LOADA, OP_LOADB: begin
              enb   <= 1'b1;
              web   <= '0;
              addrb <= word_addr(fld, 2'd0);
              state <= EXEC;
            end
            OP_MULT: state <= EXEC;
            OP_STORE: begin
              enb   <= 1'b1;
              web   <= '1;
              addrb <= word_addr(fld, 2'd0);
              dinb  <= mat_c[0][0];
              state <= EXEC;
            end
            OP_STOP: begin
              STOP_SIGNAL <= 1'b1;
              state       <= HALT;
            end
            default: begin
              PC_AXI <= pc_next;
              state  <= FETCH;
            end
          endcase
        end
        EXEC: begin
          cnt <= cnt_nxt;
          case (op)
            // BRAM read data arrives one cycle after the address, hence the one-cycle skew.
            OP_LOADA, OP_LOADB: begin
              case (cnt)
                2'd0: addrb <= word_addr(fld, 2'd1);
                2'd1: begin
                  enb <= 1'b0;
                  if (op == OP_LOADA) mat_a[fld[0]][0] <= doutb;
                  else                mat_b[fld[0]][0] <= doutb;
                end
                default: begin
                  if (op == OP_LOADA) mat_a[fld[0]][1] <= doutb;
                  else                mat_b[fld[0]][1] <= doutb;
                  PC_AXI <= pc_next;
                  state  <= FETCH;
                end
              endcase
            end
            OP_MULT: begin
              if (cnt != 2'd2) begin
                for (int unsigned i = 0; i < LANES; i++) c_tmp[cnt[0]][i] <= lane[i];
              end else begin
                mat_c  <= c_tmp;
                PC_AXI <= pc_next;
                state  <= FETCH;
              end
            end
            OP_STORE: begin
              if (cnt != 2'd3) begin
                addrb <= word_addr(fld, cnt_nxt);
                dinb  <= mat_c[cnt_nxt[1]][cnt_nxt[0]];
              end else begin
                enb    <= 1'b0;
                web    <= '0;
                PC_AXI <= pc_next;
                state  <= FETCH;
              end
            end
            default: begin
              PC_AXI <= pc_next;
              state  <= FETCH;
            end
          endcase
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_pl_core.sv
// Scoreboard bench for simd_pl_core: expected BRAM transactions are queued by the stimulus
// and checked by a negedge bus monitor; control outputs are checked directly.
module tb_simd_pl_core;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START_SIGNAL;
  logic        STOP_SIGNAL;
  logic [8:0]  PC_AXI;
  logic [31:0] INSTR_AXI;
  logic [31:0] addrb, dinb, doutb;
  logic        enb;
  logic [3:0]  web;

  logic [31:0] imem [512];
  logic [31:0] bmem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  simd_pl_core #(.N(512), .LANES(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .START_SIGNAL(START_SIGNAL), .STOP_SIGNAL(STOP_SIGNAL),
    .PC_AXI(PC_AXI), .INSTR_AXI(INSTR_AXI), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .enb(enb), .web(web)
  );

  always #5 CLK = ~CLK;

  assign INSTR_AXI = imem[PC_AXI];

  always @(posedge CLK) begin
    if (enb && web == 4'h0) doutb <= bmem[addrb[7:2]];
  end

  // Bus monitor: every enabled BRAM cycle must match the next queued transaction.
  always @(negedge CLK) begin
    if (!RSTN && enb) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bram_unexpected: got addr=%0d web=%h dinb=%0d, required no access", addrb, web, dinb);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        if (addrb !== t.addr || web !== t.we || (t.we != 4'h0 && dinb !== t.data)) begin
          errors++;
          $display("FAIL bram_txn: got addr=%0d web=%h dinb=%h, required addr=%0d web=%h dinb=%h",
                   addrb, web, dinb, t.addr, t.we, t.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    txn_t t;
    t.addr = addr; t.we = we; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    RSTN = 1'b0;
  endtask

  initial begin
    int stop_cyc;
    RSTN = 1'b1;
    START_SIGNAL = 1'b0;
    doutb = '0;
    foreach (imem[i]) imem[i] = 32'h0;
    foreach (bmem[i]) bmem[i] = 32'h0;

    // Reset state and idle with START low
    do_reset();
    #1;
    check("reset_pc", 32'(PC_AXI), 32'd0);
    check("reset_stop", 32'(STOP_SIGNAL), 32'd0);
    check("reset_enb", 32'(enb), 32'd0);
    check("reset_web", 32'(web), 32'd0);
    repeat (5) @(posedge CLK);
    #1;
    check("idle_pc", 32'(PC_AXI), 32'd0);

    // Main program: LOADA x2, LOADB x2, MULTACC, STORE, STOP
    imem[0] = 32'h2322; imem[1] = 32'h0722; imem[2] = 32'h2BA3; imem[3] = 32'h0FA3;
    imem[4] = 32'h0004; imem[5] = 32'h1205; imem[6] = 32'h0006;
    bmem[0] = 25; bmem[1] = 29; bmem[2] = 47; bmem[3] = 12;
    bmem[4] = 51; bmem[5] = 63; bmem[6] = 97; bmem[7] = 13;
    for (int k = 0; k < 8; k++) expect_txn(32'(k * 4), 4'h0, 32'h0);
    expect_txn(32, 4'hF, 4088);
    expect_txn(36, 4'hF, 1952);
    expect_txn(40, 4'hF, 3561);
    expect_txn(44, 4'hF, 3117);

    @(negedge CLK);
    START_SIGNAL = 1'b1;
    stop_cyc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge CLK);
      #1;
      if (cyc == 2) START_SIGNAL = 1'b0;
      if (cyc == 5)  check("pc_loada0_end", 32'(PC_AXI), 32'd0);
      if (cyc == 6)  check("pc_after_loada0", 32'(PC_AXI), 32'd1);
      if (cyc == 11) check("pc_after_loada1", 32'(PC_AXI), 32'd2);
      if (STOP_SIGNAL) begin
        stop_cyc = cyc;
        break;
      end
    end
    check("stop_cycle", 32'(stop_cyc), 32'd34);
    check("halt_pc", 32'(PC_AXI), 32'd6);
    check("main_txns_left", 32'(exp_q.size()), 32'd0);

    // START toggles in HALT are ignored
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      START_SIGNAL = ~START_SIGNAL;
    end
    START_SIGNAL = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("halt_pc_frozen", 32'(PC_AXI), 32'd6);
    check("halt_stop_held", 32'(STOP_SIGNAL), 32'd1);

    // Overflow program, with reset asserted in the middle of STORE
    do_reset();
    #1;
    check("reset2_stop", 32'(STOP_SIGNAL), 32'd0);
    imem[0] = 32'h0002; imem[1] = 32'h0402; imem[2] = 32'h0803; imem[3] = 32'h0C03;
    imem[4] = 32'h0004; imem[5] = 32'h1005; imem[6] = 32'h0006;
    bmem[0] = 32'hFFFF_FFFF; bmem[1] = 0; bmem[2] = 0; bmem[3] = 0;
    bmem[4] = 2; bmem[5] = 0; bmem[6] = 0; bmem[7] = 0;
    for (int k = 0; k < 8; k++) expect_txn(32'(k * 4), 4'h0, 32'h0);
    expect_txn(32, 4'hF, 32'hFFFF_FFFE);
    expect_txn(36, 4'hF, 32'h0);

    @(negedge CLK);
    START_SIGNAL = 1'b1;
    for (int cyc = 1; cyc <= 29; cyc++) begin
      @(posedge CLK);
      if (cyc == 2) START_SIGNAL = 1'b0;
    end
    #1;
    check("store_c1_web", 32'(web), 32'hF);
    check("store_c1_addr", addrb, 32'd36);
    #6;
    RSTN = 1'b1;
    #1;
    check("rst_store_web", 32'(web), 32'd0);
    check("rst_store_enb", 32'(enb), 32'd0);
    check("rst_store_pc", 32'(PC_AXI), 32'd0);
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("post_rst_web", 32'(web), 32'd0);
    check("ovf_txns_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
